mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave arbiter for the 16-bit valid/ready
// memory bus, with an abort-on-timeout for hung slave transactions.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   m0_*/m1_* valid,addr,wstrb,wdata  master requests (m0 = core)
//   m0_*/m1_* ready,rdata,err    per-master completion (err = timeout abort)
//   s_valid,s_addr,s_wstrb,s_wdata    request to the memory slave
//   s_ready,s_rdata              slave completion and read data
//   gnt                          one-hot current owner (00 = none)
//
// Parameter TIMEOUT: BUSY cycles without s_ready before abort (0 = never).
// Macro ZKTC_ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise m0 wins ties.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [15:0] m0_addr,
    input  logic [1:0]  m0_wstrb,
    input  logic [15:0] m0_wdata,
    output logic        m0_ready,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [15:0] m1_addr,
    input  logic [1:0]  m1_wstrb,
    input  logic [15:0] m1_wdata,
    output logic        m1_ready,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [15:0] s_addr,
    output logic [1:0]  s_wstrb,
    output logic [15:0] s_wdata,
    input  logic        s_ready,
    input  logic [15:0] s_rdata,
    output logic [1:0]  gnt
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_nx;
    logic          own, own_nx;
    logic          last, last_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic          win;
    logic          sel_valid;
    logic [15:0]   sel_addr;
    logic [1:0]    sel_wstrb;
    logic [15:0]   sel_wdata;
    logic          to_hit;
    logic          done;
    logic          abort;
    logic [15:0]   rdata;

    // Winner when sampling requests in IDLE.
`ifdef ZKTC_ARB_ROUND_ROBIN_EN
    assign win = (m0_valid && m1_valid) ? ~last : m1_valid;
`else
    assign win = ~m0_valid;
`endif

    assign sel_valid = own ? m1_valid : m0_valid;
    assign sel_addr  = own ? m1_addr  : m0_addr;
    assign sel_wstrb = own ? m1_wstrb : m0_wstrb;
    assign sel_wdata = own ? m1_wdata : m0_wdata;

    assign to_hit = (TIMEOUT != 0) && (cnt == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            own   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            own   <= own_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        own_nx   = own;
        last_nx  = last;
        cnt_nx   = cnt;
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wstrb  = '0;
        s_wdata  = '0;
        gnt      = 2'b00;
        done     = 1'b0;
        abort    = 1'b0;
        rdata    = '0;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    own_nx   = win;
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                gnt     = own ? 2'b10 : 2'b01;
                s_valid = sel_valid;
                s_addr  = sel_addr;
                s_wstrb = sel_wstrb;
                s_wdata = sel_wdata;
                // A completion in the timeout cycle still counts as good.
                if (s_ready) begin
                    done     = 1'b1;
                    rdata    = s_rdata;
                    last_nx  = own;
                    state_nx = IDLE;
                end else if (to_hit) begin
                    done     = 1'b1;
                    abort    = 1'b1;
                    s_valid  = 1'b0;
                    last_nx  = own;
                    state_nx = IDLE;
                end else if (!sel_valid) begin
                    state_nx = IDLE;
                end else if (cnt != TMAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m0_ready = done & ~own;
    assign m1_ready = done & own;
    assign m0_err   = abort & ~own;
    assign m1_err   = abort & own;
    assign m0_rdata = own ? 16'h0000 : rdata;
    assign m1_rdata = own ? rdata : 16'h0000;

endmodule
